// File: rtl/booth4_pkg.sv
// Shared definitions for the radix-4 Booth operand stage.
//   DATA_W : operand width (16 only)
//   NGRP   : number of Booth groups (DATA_W/2)
//   CODE_W : width of a full Booth code group
//   booth4_state_e : skid-buffer occupancy states
//   booth4_opset_t : one precomputed operand set as stored in MAIN/SKID
package booth4_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned NGRP   = DATA_W / 2;
  localparam int unsigned CODE_W = 3;
  localparam int unsigned HI_W   = (NGRP - 1) * CODE_W;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_TWO   = 2'b10
  } booth4_state_e;

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] inv_a;
    logic              a_min;
    logic [1:0]        code_pp1;
    logic [HI_W-1:0]   code_hi;
  } booth4_opset_t;

endpackage

// File: rtl/booth4_code_gen.sv
// Combinational mapping of an operand pair {A, B} to a booth4_opset_t.
//   i_a   : multiplicand A (signed)
//   i_b   : multiplier B (signed)
//   o_set : A, (~A+1) mod 2^16, A==8000h flag, pp1 code {B1,B0},
//           pp2..pp8 codes {B[2k+1],B[2k],B[2k-1]} packed low group first
module booth4_code_gen
  import booth4_pkg::*;
(
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  output booth4_opset_t     o_set
);

  // B with the implicit B[-1] = 0 appended, so group k sits at bits [2k+2:2k].
  logic [DATA_W:0] w_b_ext;

  always_comb begin
    w_b_ext        = {i_b, 1'b0};
    o_set          = '0;
    o_set.a        = i_a;
    o_set.inv_a    = ~i_a + DATA_W'(1);
    o_set.a_min    = (i_a == {1'b1, {(DATA_W-1){1'b0}}});
    o_set.code_pp1 = i_b[1:0];
    for (int unsigned k = 1; k < NGRP; k++) begin
      o_set.code_hi[CODE_W*k-1 -: CODE_W] = w_b_ext[2*k+2 -: CODE_W];
    end
  end

endmodule

// File: rtl/booth4_operand_stage.sv
// Registered operand stage of the 16x16 radix-4 Booth/Wallace multiplier.
// Accepts operand pairs over valid/ready, precomputes negated A and all
// Booth code groups, and holds them in a 2-entry skid buffer (MAIN, SKID).
//   sys_clk / sys_rst_n    : clock, asynchronous active-low reset
//   in_valid/in_ready      : input handshake; in_a, in_b operands
//   out_valid/out_ready    : output handshake
//   a_out, inv_a_out, a_min: A, (~A+1) mod 2^16, A==8000h
//   code_pp1, code_hi      : Booth codes for pp1 and pp2..pp8
module booth4_operand_stage
  import booth4_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned NGRP   = 8
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_a,
  input  logic [DATA_W-1:0]        in_b,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        a_out,
  output logic [DATA_W-1:0]        inv_a_out,
  output logic                     a_min,
  output logic [1:0]               code_pp1,
  output logic [(NGRP-1)*3-1:0]    code_hi
);

  booth4_state_e r_state;
  booth4_state_e w_state_nxt;
  booth4_opset_t r_main;
  booth4_opset_t r_skid;
  booth4_opset_t w_new_set;

  logic w_in_fire;
  logic w_out_fire;
  logic w_load_main;
  logic w_load_skid;
  logic w_main_from_skid;

  booth4_code_gen u_code_gen (
    .i_a   (in_a),
    .i_b   (in_b),
    .o_set (w_new_set)
  );

  // Handshake flags decode registered state only: no out_ready -> in_ready path.
  assign in_ready   = (r_state != ST_TWO);
  assign out_valid  = (r_state != ST_EMPTY);
  assign w_in_fire  = in_valid & in_ready;
  assign w_out_fire = out_valid & out_ready;

  always_comb begin
    w_state_nxt      = r_state;
    w_load_main      = 1'b0;
    w_load_skid      = 1'b0;
    w_main_from_skid = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (w_in_fire) begin
          w_load_main = 1'b1;
          w_state_nxt = ST_ONE;
        end
      end
      ST_ONE: begin
        case ({w_in_fire, w_out_fire})
          2'b10: begin
            w_load_skid = 1'b1;
            w_state_nxt = ST_TWO;
          end
          2'b01: w_state_nxt = ST_EMPTY;
          2'b11: w_load_main = 1'b1;
          default: ;
        endcase
      end
      ST_TWO: begin
        if (w_out_fire) begin
          w_main_from_skid = 1'b1;
          w_state_nxt      = ST_ONE;
        end
      end
      default: w_state_nxt = ST_EMPTY;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Data slots carry no reset; validity is tracked by r_state alone.
  always_ff @(posedge sys_clk) begin
    if (w_load_main) begin
      r_main <= w_new_set;
    end else if (w_main_from_skid) begin
      r_main <= r_skid;
    end
    if (w_load_skid) begin
      r_skid <= w_new_set;
    end
  end

  assign a_out     = r_main.a;
  assign inv_a_out = r_main.inv_a;
  assign a_min     = r_main.a_min;
  assign code_pp1  = r_main.code_pp1;
  assign code_hi   = r_main.code_hi;

endmodule

// File: tb/tb_booth4_operand_stage.sv
module tb_booth4_operand_stage;

  logic        sys_clk   = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        in_valid  = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] in_a      = '0;
  logic [15:0] in_b      = '0;
  logic        in_ready;
  logic        out_valid;
  logic [15:0] a_out;
  logic [15:0] inv_a_out;
  logic        a_min;
  logic [1:0]  code_pp1;
  logic [20:0] code_hi;

  int vectors     = 0;
  int miscompares = 0;
  logic [31:0] q[$];
  logic [55:0] obs;

  booth4_operand_stage #(.DATA_W(16), .NGRP(8)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .a_out     (a_out),
    .inv_a_out (inv_a_out),
    .a_min     (a_min),
    .code_pp1  (code_pp1),
    .code_hi   (code_hi)
  );

  always #5 sys_clk = ~sys_clk;

  assign obs = {a_out, inv_a_out, a_min, code_pp1, code_hi};

  // Reference: negation and Booth groups from plain integer arithmetic.
  function automatic logic [55:0] model(input logic [15:0] a, input logic [15:0] b);
    int unsigned av  = a;
    int unsigned bv  = b;
    int unsigned ext = bv * 2;
    int unsigned inv = (65536 - av) % 65536;
    int unsigned hi  = 0;
    for (int k = 1; k < 8; k++) begin
      hi += ((ext >> (2 * k)) % 8) << (3 * (k - 1));
    end
    return {16'(av), 16'(inv), (av == 32768) ? 1'b1 : 1'b0, 2'(bv % 4), 21'(hi)};
  endfunction

  task automatic test_reset();
    sys_rst_n = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge sys_clk);
    #1;
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_out_valid: got %b want 0", out_valid);
    end
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    @(posedge sys_clk);
    #1;
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release_idle: got %b want 0", out_valid);
    end
  endtask

  task automatic test_basic_codes();
    in_valid  = 1'b1;
    in_a      = 16'h1234;
    in_b      = 16'h0003;
    out_ready = 1'b1;
    @(posedge sys_clk);
    #1;
    in_valid = 1'b0;
    vectors++;
    if (out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL basic_latency: out_valid got %b want 1", out_valid);
    end
    vectors++;
    if (obs !== model(16'h1234, 16'h0003)) begin
      miscompares++;
      $display("FAIL basic_model: got %h want %h", obs, model(16'h1234, 16'h0003));
    end
    vectors++;
    if (inv_a_out !== 16'hEDCC || a_min !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_inv: got %h/%b want edcc/0", inv_a_out, a_min);
    end
    vectors++;
    if (code_pp1 !== 2'b11 || code_hi !== 21'h000001) begin
      miscompares++;
      $display("FAIL basic_codes: got %b/%h want 11/000001", code_pp1, code_hi);
    end
    @(posedge sys_clk);
    #1;
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_drain: out_valid got %b want 0", out_valid);
    end
  endtask

  task automatic test_amin();
    in_valid  = 1'b1;
    in_a      = 16'h8000;
    in_b      = 16'hFFFF;
    out_ready = 1'b1;
    @(posedge sys_clk);
    #1;
    in_valid = 1'b0;
    vectors++;
    if (out_valid !== 1'b1 || inv_a_out !== 16'h8000 || a_min !== 1'b1) begin
      miscompares++;
      $display("FAIL amin_neg: got v=%b inv=%h min=%b want 1/8000/1", out_valid, inv_a_out, a_min);
    end
    vectors++;
    if (code_pp1 !== 2'b11 || code_hi !== 21'h1FFFFF) begin
      miscompares++;
      $display("FAIL amin_codes: got %b/%h want 11/1fffff", code_pp1, code_hi);
    end
    @(posedge sys_clk);
    #1;
  endtask

  task automatic test_back_to_back();
    logic [15:0] sa[3];
    logic [15:0] sb[3];
    for (int i = 0; i < 3; i++) begin
      sa[i] = 16'($urandom);
      sb[i] = 16'($urandom);
    end
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_a = sa[0]; in_b = sb[0];
    @(posedge sys_clk); #1;
    vectors++;
    if (out_valid !== 1'b1 || in_ready !== 1'b1 || obs !== model(sa[0], sb[0])) begin
      miscompares++;
      $display("FAIL b2b_first: got v=%b r=%b %h want 1/1 %h", out_valid, in_ready, obs, model(sa[0], sb[0]));
    end
    in_a = sa[1]; in_b = sb[1];
    @(posedge sys_clk); #1;
    vectors++;
    if (in_ready !== 1'b0 || obs !== model(sa[0], sb[0])) begin
      miscompares++;
      $display("FAIL b2b_full: got r=%b %h want 0 %h", in_ready, obs, model(sa[0], sb[0]));
    end
    in_a = sa[2]; in_b = sb[2];
    @(posedge sys_clk); #1;
    vectors++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 || obs !== model(sa[0], sb[0])) begin
      miscompares++;
      $display("FAIL b2b_hold: got r=%b v=%b %h want 0/1 %h", in_ready, out_valid, obs, model(sa[0], sb[0]));
    end
    out_ready = 1'b1;
    @(posedge sys_clk); #1;
    vectors++;
    if (out_valid !== 1'b1 || in_ready !== 1'b1 || obs !== model(sa[1], sb[1])) begin
      miscompares++;
      $display("FAIL b2b_second: got v=%b r=%b %h want 1/1 %h", out_valid, in_ready, obs, model(sa[1], sb[1]));
    end
    @(posedge sys_clk); #1;
    in_valid = 1'b0;
    vectors++;
    if (out_valid !== 1'b1 || obs !== model(sa[2], sb[2])) begin
      miscompares++;
      $display("FAIL b2b_third: got v=%b %h want 1 %h", out_valid, obs, model(sa[2], sb[2]));
    end
    @(posedge sys_clk); #1;
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_empty: out_valid got %b want 0", out_valid);
    end
  endtask

  task automatic test_stream();
    int got = 0;
    q.delete();
    out_ready = 1'b1;
    for (int i = 0; i < 102; i++) begin
      if (i < 100) begin
        in_valid = 1'b1;
        in_a = 16'($urandom);
        in_b = 16'($urandom);
      end else begin
        in_valid = 1'b0;
      end
      @(negedge sys_clk);
      if (i < 100) begin
        vectors++;
        if (in_ready !== 1'b1) begin
          miscompares++;
          $display("FAIL stream_in_ready cycle %0d: got %b want 1", i, in_ready);
        end
      end
      if (i >= 1 && i <= 100) begin
        vectors++;
        if (out_valid !== 1'b1) begin
          miscompares++;
          $display("FAIL stream_gap cycle %0d: out_valid got %b want 1", i, out_valid);
        end
      end
      if (out_valid === 1'b1) begin
        vectors++;
        if (q.size() == 0) begin
          miscompares++;
          $display("FAIL stream_extra: got %h want nothing", obs);
        end else begin
          if (obs !== model(q[0][31:16], q[0][15:0])) begin
            miscompares++;
            $display("FAIL stream_data: got %h want %h", obs, model(q[0][31:16], q[0][15:0]));
          end
          void'(q.pop_front());
          got++;
        end
      end
      if (in_valid && in_ready) q.push_back({in_a, in_b});
      @(posedge sys_clk); #1;
    end
    vectors++;
    if (got != 100 || q.size() != 0) begin
      miscompares++;
      $display("FAIL stream_count: got %0d delivered %0d left want 100/0", got, q.size());
    end
  endtask

  task automatic test_random();
    logic        prev_stall = 1'b0;
    logic [55:0] prev_obs   = '0;
    int pushed = 0;
    int popped = 0;
    q.delete();
    for (int i = 0; i < 10000; i++) begin
      in_valid  = 1'($urandom % 2);
      in_a      = 16'($urandom);
      in_b      = 16'($urandom);
      out_ready = 1'($urandom % 2);
      @(negedge sys_clk);
      vectors++;
      if (in_ready !== (q.size() < 2) || out_valid !== (q.size() != 0)) begin
        miscompares++;
        $display("FAIL rand_flags cycle %0d: got r=%b v=%b want occupancy %0d", i, in_ready, out_valid, q.size());
      end
      if (prev_stall) begin
        vectors++;
        if (obs !== prev_obs) begin
          miscompares++;
          $display("FAIL rand_stall_stable cycle %0d: got %h want %h", i, obs, prev_obs);
        end
      end
      if (out_valid === 1'b1 && q.size() != 0) begin
        vectors++;
        if (obs !== model(q[0][31:16], q[0][15:0])) begin
          miscompares++;
          $display("FAIL rand_data cycle %0d: got %h want %h", i, obs, model(q[0][31:16], q[0][15:0]));
        end
        if (out_ready) begin
          void'(q.pop_front());
          popped++;
        end
      end
      if (in_valid && in_ready) begin
        q.push_back({in_a, in_b});
        pushed++;
      end
      prev_stall = out_valid & ~out_ready;
      prev_obs   = obs;
      @(posedge sys_clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge sys_clk);
      if (out_valid === 1'b1 && q.size() != 0) begin
        vectors++;
        if (obs !== model(q[0][31:16], q[0][15:0])) begin
          miscompares++;
          $display("FAIL rand_drain_data: got %h want %h", obs, model(q[0][31:16], q[0][15:0]));
        end
        void'(q.pop_front());
        popped++;
      end
      @(posedge sys_clk); #1;
    end
    vectors++;
    if (out_valid !== 1'b0 || q.size() != 0 || pushed != popped) begin
      miscompares++;
      $display("FAIL rand_conservation: got v=%b left=%0d in=%0d out=%0d want 0/0 equal", out_valid, q.size(), pushed, popped);
    end
  endtask

  task automatic test_async_reset();
    logic [15:0] xa = 16'($urandom);
    logic [15:0] xb = 16'($urandom);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_a = 16'h1111; in_b = 16'h2222;
    @(posedge sys_clk); #1;
    in_a = 16'h3333; in_b = 16'h4444;
    @(posedge sys_clk); #1;
    in_valid = 1'b0;
    vectors++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL arst_setup_full: got r=%b v=%b want 0/1", in_ready, out_valid);
    end
    #2;
    sys_rst_n = 1'b0;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL arst_immediate: got v=%b r=%b want 0/1", out_valid, in_ready);
    end
    @(posedge sys_clk);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    in_valid  = 1'b1;
    in_a = xa; in_b = xb;
    @(posedge sys_clk); #1;
    in_valid = 1'b0;
    vectors++;
    if (out_valid !== 1'b1 || obs !== model(xa, xb)) begin
      miscompares++;
      $display("FAIL arst_first_set: got v=%b %h want 1 %h", out_valid, obs, model(xa, xb));
    end
    out_ready = 1'b1;
    @(posedge sys_clk); #1;
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL arst_alone: out_valid got %b want 0", out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_basic_codes();
    test_amin();
    test_back_to_back();
    test_stream();
    test_random();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
